// File: rtl/depth_frame_render.sv
// depth_frame_render: nested perspective frames, corner diagonals and depth-band highlight; define DEPTH_BLINK_EN to blink the highlight at the walls
module depth_frame_render #(
  parameter int          NUM_FRAMES   = 9,
  parameter int          H_RES        = 640,
  parameter int          V_RES        = 480,
  parameter int          Z_FIRST      = 63,
  parameter int          Z_STEP       = 125,
  parameter logic [23:0] FRAME_COLOR  = 24'h00FF00,
  parameter logic [23:0] HILITE_COLOR = 24'h66FFFF,
  parameter logic [23:0] BG_COLOR     = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        VGA_Ready,
  input  logic [15:0] pixel_x,
  input  logic [15:0] pixel_y,
  input  logic [15:0] ball_z,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [15:0] cfg_x,
  input  logic [15:0] cfg_y,
  input  logic [15:0] cfg_w,
  input  logic [15:0] cfg_h,
  output logic [3:0]  band,
  output logic        busy,
  output logic [23:0] color,
  output logic        color_valid
);
  localparam int          LI   = NUM_FRAMES - 1;
  localparam logic [3:0]  LAST = 4'(NUM_FRAMES - 1);
  localparam logic [15:0] ZF   = 16'(Z_FIRST);
  localparam logic [15:0] ZS   = 16'(Z_STEP);
  typedef enum logic [1:0] {IDLE, LOAD, SUB, DONE} state_t;
  state_t r_state, w_state_nx;
  logic [15:0] r_tx [NUM_FRAMES];
  logic [15:0] r_ty [NUM_FRAMES];
  logic [15:0] r_tw [NUM_FRAMES];
  logic [15:0] r_th [NUM_FRAMES];
  logic [15:0] r_work, w_work_nx;
  logic [3:0]  r_acc, w_acc_nx, r_band, w_band_nx;
  logic        r_busy, w_busy_nx;
  logic        w_trig, w_eol, w_dim, w_geo_ok;
  logic [15:0] w_ny, w_x0r, w_y0b, w_xlr, w_ylb;
  logic [NUM_FRAMES-1:0] w_rect, w_rect_hl;
  logic [3:0]  w_diag;
  logic [23:0] w_color;
  logic [15:0] w_lxs [4];
  logic [15:0] w_lys [4];
  logic [15:0] w_lxe [4];
  logic [15:0] w_lye [4];
  assign w_eol  = VGA_Ready && pixel_x == 16'(H_RES - 1);
  assign w_trig = w_eol && pixel_y == 16'(V_RES - 1);
  assign w_ny   = pixel_y == 16'(V_RES - 1) ? 16'd0 : pixel_y + 16'd1;
  assign band   = r_band;
  assign busy   = r_busy;
  // geometry table; indices beyond the table match no entry and are dropped
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_FRAMES; i++)
      if (rst) begin
        r_tx[i] <= '0;
        r_ty[i] <= '0;
        r_tw[i] <= '0;
        r_th[i] <= '0;
      end else if (cfg_we && cfg_idx == 4'(i)) begin
        r_tx[i] <= cfg_x;
        r_ty[i] <= cfg_y;
        r_tw[i] <= cfg_w;
        r_th[i] <= cfg_h;
      end
  for (genvar k = 0; k < NUM_FRAMES; k++) begin : g_rect
    logic [16:0] w_xe, w_ye;
    logic        w_ix, w_iy;
    assign w_xe = {1'b0, r_tx[k]} + {1'b0, r_tw[k]};
    assign w_ye = {1'b0, r_ty[k]} + {1'b0, r_th[k]};
    assign w_ix = pixel_x >= r_tx[k] && {1'b0, pixel_x} < w_xe;
    assign w_iy = pixel_y >= r_ty[k] && {1'b0, pixel_y} < w_ye;
    assign w_rect[k] = r_tw[k] != 0 && r_th[k] != 0 &&
      ((w_ix && (pixel_y == r_ty[k] || {1'b0, pixel_y} + 17'd1 == w_ye)) ||
       (w_iy && (pixel_x == r_tx[k] || {1'b0, pixel_x} + 17'd1 == w_xe)));
    assign w_rect_hl[k] = w_rect[k] && r_band == 4'(k);
  end
  assign w_x0r    = r_tx[0] + r_tw[0] - 16'd1;
  assign w_y0b    = r_ty[0] + r_th[0] - 16'd1;
  assign w_xlr    = r_tx[LI] + r_tw[LI] - 16'd1;
  assign w_ylb    = r_ty[LI] + r_th[LI] - 16'd1;
  assign w_geo_ok = r_tw[0] != 0 && r_th[0] != 0 && r_tw[LI] != 0 && r_th[LI] != 0;
  // lines always run downward: top pair starts at entry 0, bottom pair at the inner entry
  assign w_lxs = '{r_tx[0], w_x0r, r_tx[LI], w_xlr};
  assign w_lys = '{r_ty[0], r_ty[0], w_ylb, w_ylb};
  assign w_lxe = '{r_tx[LI], w_xlr, r_tx[0], w_x0r};
  assign w_lye = '{r_ty[LI], r_ty[LI], w_y0b, w_y0b};
  for (genvar j = 0; j < 4; j++) begin : g_line
    logic        w_left, w_cy;
    logic [15:0] w_dx, w_dy, w_dys, w_q, w_r, w_step;
    logic [16:0] w_sum;
    logic [15:0] r_x, r_err;
    logic        r_cy;
    assign w_left = w_lxe[j] < w_lxs[j];
    assign w_dx   = w_left ? w_lxs[j] - w_lxe[j] : w_lxe[j] - w_lxs[j];
    assign w_dy   = w_lye[j] > w_lys[j] ? w_lye[j] - w_lys[j] : 16'd0;
    assign w_dys  = w_dy == 0 ? 16'd1 : w_dy;
    assign w_q    = w_dx / w_dys;
    assign w_r    = w_dx % w_dys;
    assign w_sum  = {1'b0, r_err} + {1'b0, w_r};
    assign w_cy   = w_sum >= {1'b0, w_dys};
    assign w_step = w_q + {15'd0, w_cy};
    // per-line DDA step; a carried row is drawn one pixel wider to close the gap
    always_ff @(posedge clk)
      if (rst) begin
        r_x   <= '0;
        r_err <= '0;
        r_cy  <= 1'b0;
      end else if (w_eol) begin
        if (w_ny == r_ty[0]) begin
          r_x   <= w_lxs[j];
          r_err <= '0;
          r_cy  <= 1'b0;
        end else if (pixel_y >= w_lys[j] && pixel_y < w_lye[j]) begin
          r_x   <= w_left ? r_x - w_step : r_x + w_step;
          r_err <= w_cy ? 16'(w_sum - {1'b0, w_dys}) : w_sum[15:0];
          r_cy  <= w_cy;
        end
      end
    assign w_diag[j] = w_geo_ok && w_dy != 0 && pixel_y >= w_lys[j] && pixel_y <= w_lye[j] &&
      {1'b0, pixel_x} + {16'd0, r_cy | w_left} >= {1'b0, r_x} &&
      {1'b0, pixel_x} <= {1'b0, r_x} + {16'd0, r_cy | ~w_left};
  end
`ifdef DEPTH_BLINK_EN
  logic [2:0] r_blink;
  // video-frame counter pacing the wall blink
  always_ff @(posedge clk)
    if (rst) r_blink <= '0;
    else if (w_trig) r_blink <= r_blink + 3'd1;
  assign w_dim = (r_band == LAST || r_band == 4'd0) && r_blink[2];
`else
  assign w_dim = 1'b0;
`endif
  assign w_color = |w_rect_hl ? (w_dim ? FRAME_COLOR : HILITE_COLOR) :
                   (|w_rect || |w_diag) ? FRAME_COLOR : BG_COLOR;
  // one-clock pixel pipeline; color holds while the VGA side stalls
  always_ff @(posedge clk)
    if (rst) begin
      color       <= BG_COLOR;
      color_valid <= 1'b0;
    end else begin
      color_valid <= VGA_Ready;
      if (VGA_Ready) color <= w_color;
    end
  // depth FSM state and datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_acc   <= '0;
      r_band  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_work  <= w_work_nx;
      r_acc   <= w_acc_nx;
      r_band  <= w_band_nx;
      r_busy  <= w_busy_nx;
    end
  // serial band search, one Z_STEP subtraction per clock, started at frame end
  always_comb begin
    w_state_nx = r_state;
    w_work_nx  = r_work;
    w_acc_nx   = r_acc;
    w_band_nx  = r_band;
    w_busy_nx  = r_busy;
    case (r_state)
      IDLE: if (w_trig) begin
        w_state_nx = LOAD;
        w_busy_nx  = 1'b1;
      end
      LOAD: begin
        w_work_nx  = ball_z < ZF ? ball_z : ball_z - ZF;
        w_acc_nx   = ball_z < ZF ? 4'd0 : 4'd1;
        w_state_nx = ball_z < ZF ? DONE : SUB;
      end
      SUB: if (r_work >= ZS && r_acc < LAST) begin
        w_work_nx = r_work - ZS;
        w_acc_nx  = r_acc + 4'd1;
      end else w_state_nx = DONE;
      DONE: begin
        w_band_nx  = r_acc;
        w_busy_nx  = 1'b0;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_depth_frame_render.sv
// tb_depth_frame_render: directed checks of band search, outline/highlight colors and diagonals
module tb_depth_frame_render;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] HIL = 24'h66FFFF;
  localparam logic [23:0] BG  = 24'h000000;
  logic        clk = 1'b0, rst = 1'b1, VGA_Ready = 1'b0, cfg_we = 1'b0;
  logic [15:0] pixel_x = '0, pixel_y = '0, ball_z = '0;
  logic [3:0]  cfg_idx = '0;
  logic [15:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
  logic [3:0]  band;
  logic        busy, color_valid;
  logic [23:0] color;
  int n_chk = 0, n_err = 0;
  depth_frame_render dut (
    .clk(clk), .rst(rst), .VGA_Ready(VGA_Ready), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .ball_z(ball_z), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .band(band), .busy(busy), .color(color),
    .color_valid(color_valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] i, input logic [15:0] x, y, w, h);
    cfg_we = 1'b1; cfg_idx = i; cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic pix(input logic [15:0] x, y);
    VGA_Ready = 1'b1; pixel_x = x; pixel_y = y;
    tick();
    VGA_Ready = 1'b0;
  endtask
  task automatic pix_chk(input string tag, input logic [15:0] x, y, input logic [23:0] exp);
    pix(x, y);
    check(tag, color, exp);
  endtask
  task automatic run_frame(input logic [15:0] z, input logic [3:0] eb, input int ecyc);
    int n;
    ball_z = z;
    pix(16'd639, 16'd479);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("busy_cycles", n, ecyc);
    check("band", band, eb);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    VGA_Ready = 1'b1; pixel_x = 16'd63; pixel_y = 16'd47;
    tick(); tick();
    check("rst_color", color, BG);
    check("rst_valid", color_valid, 0);
    check("rst_band", band, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; VGA_Ready = 1'b0;
    wr(4'd0, 16'd63, 16'd47, 16'd514, 16'd386);
    wr(4'd3, 16'd197, 16'd148, 16'd246, 16'd184);
    wr(4'd8, 16'd255, 16'd191, 16'd130, 16'd98);
    run_frame(16'd187, 4'd1, 3);
    run_frame(16'd188, 4'd2, 4);
    run_frame(16'd0, 4'd0, 2);
    pix_chk("hilite_e0", 16'd63, 16'd47, HIL);
    check("valid_hi", color_valid, 1);
    tick();
    check("valid_lo", color_valid, 0);
    check("color_hold", color, HIL);
    pix_chk("frame_e3", 16'd197, 16'd148, GRN);
    pix_chk("bg_inside", 16'd100, 16'd100, BG);
    wr(4'd3, 16'd197, 16'd148, 16'd0, 16'd184);
    pix_chk("empty_e3", 16'd197, 16'd148, BG);
    wr(4'd12, 16'd0, 16'd0, 16'd5, 16'd5);
    pix_chk("idx12_ignored", 16'd0, 16'd0, BG);
    pix_chk("idx12_e0_kept", 16'd63, 16'd47, HIL);
    ball_z = 16'd500;
    pix_chk("midframe_px", 16'd320, 16'd240, BG);
    tick(); tick(); tick();
    check("midframe_band", band, 0);
    run_frame(16'd500, 4'd4, 6);
    run_frame(16'd938, 4'd8, 10);
    run_frame(16'hFFFF, 4'd8, 10);
    pix_chk("hilite_e8", 16'd300, 16'd191, HIL);
    pix_chk("e0_not_hilite", 16'd63, 16'd47, GRN);
    ball_z = 16'd900;
    pix(16'd639, 16'd479);
    pix_chk("sub_color", 16'd300, 16'd191, HIL);
    check("sub_busy", busy, 1);
    rst = 1'b1; VGA_Ready = 1'b1;
    tick();
    rst = 1'b0; VGA_Ready = 1'b0;
    check("midrst_band", band, 0);
    check("midrst_busy", busy, 0);
    check("midrst_color", color, BG);
    check("midrst_valid", color_valid, 0);
    for (int i = 0; i < 12; i++) tick();
    check("midrst_idle_band", band, 0);
    check("midrst_idle_busy", busy, 0);
    wr(4'd0, 16'd63, 16'd47, 16'd514, 16'd386);
    wr(4'd8, 16'd255, 16'd191, 16'd130, 16'd98);
    pix(16'd639, 16'd46);
    pix_chk("d_r47", 16'd64, 16'd47, HIL);
    pix(16'd639, 16'd47);
    pix_chk("d_r48_in", 16'd65, 16'd48, GRN);
    pix_chk("d_r48_out", 16'd66, 16'd48, BG);
    pix_chk("d_tr48_in", 16'd574, 16'd48, GRN);
    pix_chk("d_tr48_out", 16'd573, 16'd48, BG);
    pix(16'd639, 16'd48);
    pix_chk("d_r49_in", 16'd66, 16'd49, GRN);
    pix_chk("d_r49_out", 16'd67, 16'd49, BG);
    pix(16'd639, 16'd49);
    pix_chk("d_r50_lo", 16'd66, 16'd50, GRN);
    pix_chk("d_r50_hi", 16'd68, 16'd50, GRN);
    pix_chk("d_r50_left", 16'd65, 16'd50, BG);
    pix_chk("d_r50_right", 16'd69, 16'd50, BG);
    for (int y = 50; y < 191; y++) pix(16'd639, 16'(y));
    pix_chk("d_r191_lo", 16'd254, 16'd191, GRN);
    pix_chk("d_r191_out", 16'd253, 16'd191, BG);
    pix_chk("d_r191_hi", 16'd256, 16'd191, GRN);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
